// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - word-addressed instruction memory answering IF fetches after programmable wait states
module imem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iport_address,
  input  logic        iport_valid,
  output logic [31:0] iport_data,
  output logic        iport_ready,
  output logic        iport_error,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int          CW      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0] addr_q, addr_next;
  logic        load_resp;

  logic [31:0] mem [DEPTH];

  // Decode of the latched fetch address and of the preload address
  logic [31:0] rd_off, wr_off;
  logic        rd_ok, wr_ok;

  assign rd_off = addr_q - BASE_ADDR;
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_ok  = (addr_q[1:0] == 2'b00) && (addr_q >= BASE_ADDR) && (rd_off[31:2] < DEPTH_W);
  assign wr_ok  = (wr_addr[1:0] == 2'b00) && (wr_addr >= BASE_ADDR) && (wr_off[31:2] < DEPTH_W);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr_q;
    load_resp  = 1'b0;
    case (state)
      IDLE: begin
        if (iport_valid) begin
          addr_next  = iport_address;
          cnt_next   = CW'(WAIT_CYCLES);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          load_resp  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      iport_ready <= 1'b0;
      iport_data  <= '0;
      iport_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      addr_q      <= addr_next;
      iport_ready <= load_resp;
      if (load_resp) begin
        iport_data  <= rd_ok ? mem[rd_off[AW+1:2]] : 32'h0;
        iport_error <= !rd_ok;
      end
    end
  end

  // Preload stays live through reset; a same-edge fetch sees the old word
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_off[AW+1:2]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder at three wait-state settings
module tb_imem_responder;

  localparam int NI = 3;

  logic        clk;
  logic        rst     [NI];
  logic        valid   [NI];
  logic [31:0] addr    [NI];
  logic [31:0] data    [NI];
  logic        rdy     [NI];
  logic        err     [NI];
  logic        wr_en   [NI];
  logic [31:0] wr_addr [NI];
  logic [31:0] wr_data [NI];

  logic [31:0] mdl [NI][1024];
  int npass;
  int ntotal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    imem_responder #(
      .DEPTH(1024), .WAIT_CYCLES(W), .BASE_ADDR(32'h0), .INIT_FILE("")
    ) dut (
      .clk(clk), .rst(rst[g]),
      .iport_address(addr[g]), .iport_valid(valid[g]),
      .iport_data(data[g]), .iport_ready(rdy[g]), .iport_error(err[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g])
    );
  end

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
  endfunction

  function automatic logic [31:0] exp_data(input int i, input logic [31:0] a);
    return exp_err(a) ? 32'h0 : mdl[i][a[11:2]];
  endfunction

  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d);
    wr_en[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d;
    @(posedge clk); #1;
    wr_en[i] = 1'b0;
    if (!exp_err(a)) mdl[i][a[11:2]] = d;
  endtask

  // lat = edges after acceptance E0 until ready is first seen; extra = ready samples after the pulse
  task automatic fetch(input int i, input logic [31:0] a, input bit chg,
                       output int lat, output logic [31:0] d, output logic e, output int extra);
    valid[i] = 1'b1; addr[i] = a;
    lat = -1; d = 32'hx; e = 1'bx; extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (chg && k == 0) addr[i] = a + 32'd4;
      if (rdy[i]) begin
        lat = k; d = data[i]; e = err[i];
        break;
      end
    end
    valid[i] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy[i]) extra++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; valid[i] = 1'b0; addr[i] = '0;
      wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    repeat (2) begin @(posedge clk); #1; end
    do_write(1, 32'h8, 32'h00a00093);
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      ntotal++; if (rdy[i] !== 1'b0) $display("FAIL reset_ready[%0d] got %b want 0", i, rdy[i]); else npass++;
      ntotal++; if (data[i] !== 32'h0) $display("FAIL reset_data[%0d] got %h want 0", i, data[i]); else npass++;
      ntotal++; if (err[i] !== 1'b0) $display("FAIL reset_error[%0d] got %b want 0", i, err[i]); else npass++;
    end
  endtask

  task automatic test_basic();
    int lat, extra; logic [31:0] d; logic e;
    logic [31:0] as [2];
    as[0] = 32'h0; as[1] = 32'h4;
    for (int i = 0; i < NI; i++) begin
      do_write(i, 32'h0, 32'hfff70713);
      do_write(i, 32'h4, 32'h0016f793);
    end
    for (int j = 0; j < 2; j++) begin
      fetch(0, as[j], 1'b0, lat, d, e, extra);
      ntotal++; if (lat !== wait_of(0) + 1) $display("FAIL basic_latency[%0d] got %0d want %0d", j, lat, wait_of(0) + 1); else npass++;
      ntotal++; if (d !== exp_data(0, as[j])) $display("FAIL basic_data[%0d] got %h want %h", j, d, exp_data(0, as[j])); else npass++;
      ntotal++; if (e !== 1'b0) $display("FAIL basic_error[%0d] got %b want 0", j, e); else npass++;
      ntotal++; if (extra !== 0) $display("FAIL basic_single_pulse[%0d] got %0d extra want 0", j, extra); else npass++;
      ntotal++; if (data[0] !== exp_data(0, as[j])) $display("FAIL basic_data_hold[%0d] got %h want %h", j, data[0], exp_data(0, as[j])); else npass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] as [3];
    int pos [3];
    logic [31:0] got [3];
    int idx = 0;
    bit last_r = 0, consec = 0;
    as[0] = 32'h0; as[1] = 32'h4; as[2] = 32'h8;
    for (int j = 0; j < 3; j++) begin pos[j] = -1; got[j] = 32'hx; end
    valid[1] = 1'b1; addr[1] = as[0];
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rdy[1] && last_r) consec = 1;
      last_r = rdy[1];
      if (rdy[1] && idx < 3) begin
        pos[idx] = k; got[idx] = data[1]; idx++;
        if (idx < 3) addr[1] = as[idx]; else valid[1] = 1'b0;
      end
    end
    valid[1] = 1'b0;
    ntotal++; if (idx !== 3) $display("FAIL b2b_count got %0d want 3", idx); else npass++;
    ntotal++; if (consec !== 0) $display("FAIL b2b_ready_twice got %0d want 0", consec); else npass++;
    for (int j = 0; j < 3; j++) begin
      ntotal++; if (pos[j] !== 1 + 3 * j) $display("FAIL b2b_pos[%0d] got %0d want %0d", j, pos[j], 1 + 3 * j); else npass++;
      ntotal++; if (got[j] !== exp_data(1, as[j])) $display("FAIL b2b_data[%0d] got %h want %h", j, got[j], exp_data(1, as[j])); else npass++;
    end
  endtask

  task automatic test_errors();
    int lat, extra; logic [31:0] d; logic e;
    logic [31:0] as [3];
    as[0] = 32'h2; as[1] = 32'h1000; as[2] = 32'h4;
    for (int j = 0; j < 3; j++) begin
      fetch(0, as[j], 1'b0, lat, d, e, extra);
      ntotal++; if (lat !== wait_of(0) + 1) $display("FAIL err_latency[%0d] got %0d want %0d", j, lat, wait_of(0) + 1); else npass++;
      ntotal++; if (e !== exp_err(as[j])) $display("FAIL err_flag[%0d] got %b want %b", j, e, exp_err(as[j])); else npass++;
      ntotal++; if (d !== exp_data(0, as[j])) $display("FAIL err_data[%0d] got %h want %h", j, d, exp_data(0, as[j])); else npass++;
    end
  endtask

  task automatic test_addr_change();
    int lat, extra; logic [31:0] d; logic e;
    fetch(2, 32'h0, 1'b1, lat, d, e, extra);
    ntotal++; if (lat !== wait_of(2) + 1) $display("FAIL latch_latency got %0d want %0d", lat, wait_of(2) + 1); else npass++;
    ntotal++; if (d !== 32'hfff70713) $display("FAIL latch_data got %h want fff70713", d); else npass++;
    ntotal++; if (extra !== 0) $display("FAIL latch_single_pulse got %0d extra want 0", extra); else npass++;
  endtask

  task automatic test_reset_mid();
    int lat, extra, pulses = 0; logic [31:0] d; logic e;
    valid[0] = 1'b1; addr[0] = 32'h4;
    @(posedge clk); #1;
    valid[0] = 1'b0; rst[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[0]) pulses++;
    end
    ntotal++; if (pulses !== 0) $display("FAIL midreset_no_pulse got %0d want 0", pulses); else npass++;
    fetch(0, 32'h4, 1'b0, lat, d, e, extra);
    ntotal++; if (lat !== wait_of(0) + 1) $display("FAIL midreset_latency got %0d want %0d", lat, wait_of(0) + 1); else npass++;
    ntotal++; if (d !== 32'h0016f793) $display("FAIL midreset_data got %h want 0016f793", d); else npass++;
  endtask

  task automatic test_read_before_write();
    int lat, extra; logic [31:0] d; logic e;
    logic [31:0] old = exp_data(0, 32'h4);
    valid[0] = 1'b1; addr[0] = 32'h4;
    repeat (wait_of(0) + 1) begin @(posedge clk); #1; end
    wr_en[0] = 1'b1; wr_addr[0] = 32'h4; wr_data[0] = 32'hdeadbeef;
    @(posedge clk); #1;
    wr_en[0] = 1'b0; valid[0] = 1'b0;
    mdl[0][1] = 32'hdeadbeef;
    ntotal++; if (rdy[0] !== 1'b1) $display("FAIL rbw_ready got %b want 1", rdy[0]); else npass++;
    ntotal++; if (data[0] !== old) $display("FAIL rbw_old_data got %h want %h", data[0], old); else npass++;
    repeat (2) begin @(posedge clk); #1; end
    fetch(0, 32'h4, 1'b0, lat, d, e, extra);
    ntotal++; if (d !== 32'hdeadbeef) $display("FAIL rbw_new_data got %h want deadbeef", d); else npass++;
  endtask

  task automatic test_random();
    int lat, extra; logic [31:0] d; logic e; logic [31:0] a;
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 16; j++) do_write(i, 32'(j * 4), $urandom);
      for (int j = 0; j < 8; j++) do_write(i, {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, $urandom);
      for (int j = 0; j < 8; j++) begin
        case ($urandom_range(0, 3))
          0: a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
          1: a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
          2: a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
          default: a = 32'hffff_fffc;
        endcase
        fetch(i, a, 1'b0, lat, d, e, extra);
        ntotal++; if (lat !== wait_of(i) + 1) $display("FAIL rand_latency[%0d] addr %h got %0d want %0d", i, a, lat, wait_of(i) + 1); else npass++;
        ntotal++; if (e !== exp_err(a)) $display("FAIL rand_error[%0d] addr %h got %b want %b", i, a, e, exp_err(a)); else npass++;
        ntotal++; if (d !== exp_data(i, a)) $display("FAIL rand_data[%0d] addr %h got %h want %h", i, a, d, exp_data(i, a)); else npass++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    npass = 0; ntotal = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_addr_change();
    test_reset_mid();
    test_read_before_write();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
